// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks.
//   parity_e      : parity selection, decoded from the 2-bit parity_mode input
//   tx_state_e    : transmitter FSM states
//   bit_period()  : clock cycles per line bit (truncating integer divide)
//   decode_parity(): maps the raw 2-bit mode onto parity_e (11 behaves as none)
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic int unsigned bit_period(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous single-clock FIFO with first-word fall-through read data.
// Shared with the receive path, so it carries no UART-specific logic.
//   clk, rst_n : clock, synchronous active-low reset (flushes pointers/count)
//   push/wdata : write request and data; ignored while full
//   pop/rdata  : read request; rdata always shows the head entry
//   count      : occupancy 0..DEPTH
//   full/empty : occupancy flags derived from the registered count
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; only pointers and count
  // define validity, and a resettable array would cost a flop-based memory.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a DEPTH-entry FIFO.
//   clk, rst_n        : clock, synchronous active-low reset
//   s_data/s_valid    : upstream word and valid; accepted when s_ready is high
//   s_ready           : FIFO not full (registered count only)
//   parity_mode       : 00 none, 01 even, 10 odd, 11 none; latched per frame
//   two_stop          : 0 one stop bit, 1 two stop bits; latched per frame
//   tx                : serial line, idle high
//   busy              : high for every cycle of a frame
//   frame_done        : one-cycle pulse on the final stop-bit cycle
//   fifo_count        : FIFO occupancy
// All serial outputs are registered from the FSM's next-state values, so the
// line never has a combinational path from any input.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_BITS-1:0]       s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [1:0]                 parity_mode,
  input  logic                       two_stop,
  output logic                       tx,
  output logic                       busy,
  output logic                       frame_done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int unsigned BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int TMR_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be within 5..9");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end
  if (BIT_PERIOD < 2) begin : g_bad_bit_period
    $error("uart_tx_fifo: CLK_FREQ / BAUD_RATE must be >= 2");
  end

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 push;
  logic                 pop;

  assign s_ready = !fifo_full;
  assign push    = s_valid && !fifo_full;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .rdata (fifo_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  tx_state_e            state_q,    state_n;
  logic [TMR_W-1:0]     timer_q,    timer_n;
  logic [IDX_W-1:0]     idx_q,      idx_n;
  logic [DATA_BITS-1:0] shift_q,    shift_n;
  parity_e              par_mode_q, par_mode_n;
  logic                 par_bit_q,  par_bit_n;
  logic                 two_q,      two_n;
  logic                 stop2_q,    stop2_n;   // set while sending the second stop bit
  logic                 tx_n;
  logic                 busy_n;
  logic                 done_n;
  logic                 bit_end;

  assign bit_end = (timer_q == TMR_LAST);

  // NOTE: every variable driven here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state_q;
    timer_n    = timer_q;
    idx_n      = idx_q;
    shift_n    = shift_q;
    par_mode_n = par_mode_q;
    par_bit_n  = par_bit_q;
    two_n      = two_q;
    stop2_n    = stop2_q;
    pop        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_n    = fifo_data;
          par_mode_n = decode_parity(parity_mode);
          // Parity is fixed at load time because the shift register is
          // consumed while the data bits go out.
          par_bit_n  = (^fifo_data) ^ (decode_parity(parity_mode) == PAR_ODD);
          two_n      = two_stop;
          timer_n    = '0;
          state_n    = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          timer_n = '0;
          idx_n   = '0;
          state_n = ST_DATA;
        end else begin
          timer_n = timer_q + TMR_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          timer_n = '0;
          shift_n = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            stop2_n = 1'b0;
            state_n = (par_mode_q == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end else begin
          timer_n = timer_q + TMR_W'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          timer_n = '0;
          stop2_n = 1'b0;
          state_n = ST_STOP;
        end else begin
          timer_n = timer_q + TMR_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          timer_n = '0;
          if (two_q && !stop2_q) stop2_n = 1'b1;
          else                   state_n = ST_IDLE;
        end else begin
          timer_n = timer_q + TMR_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Outputs are decoded from next-state values and then registered, so the
    // pin shows the level belonging to the state the FSM is in.
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_n[0];
      ST_PARITY: tx_n = par_bit_n;
      default:   tx_n = 1'b1;
    endcase
    busy_n = (state_n != ST_IDLE);
    done_n = (state_n == ST_STOP) && (timer_n == TMR_LAST) && (!two_n || stop2_n);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_mode_q <= PAR_NONE;
      par_bit_q  <= 1'b0;
      two_q      <= 1'b0;
      stop2_q    <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      timer_q    <= timer_n;
      idx_q      <= idx_n;
      shift_q    <= shift_n;
      par_mode_q <= par_mode_n;
      par_bit_q  <= par_bit_n;
      two_q      <= two_n;
      stop2_q    <= stop2_n;
      tx         <= tx_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. Two instances share clk/rst_n:
// dut_a (DATA_BITS=8) and dut_b (DATA_BITS=5), both BIT_PERIOD=10, DEPTH=4.
// A reference model turns each popped word into its list of line bits,
// expands that into per-cycle expected {tx,busy,frame_done} samples and
// compares every cycle, alongside FIFO occupancy and s_ready.
module tb_uart_tx_fifo;

  localparam int BP    = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data_a;
  logic       s_valid_a, s_ready_a, ts_a, tx_a, busy_a, done_a;
  logic [1:0] pm_a;
  logic [2:0] count_a;
  logic [4:0] s_data_b;
  logic       s_valid_b, s_ready_b, ts_b, tx_b, busy_b, done_b;
  logic [1:0] pm_b;
  logic [2:0] count_b;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .DEPTH(DEPTH)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_a), .s_valid(s_valid_a),
    .s_ready(s_ready_a), .parity_mode(pm_a), .two_stop(ts_a), .tx(tx_a),
    .busy(busy_a), .frame_done(done_a), .fifo_count(count_a)
  );

  uart_tx_fifo #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(5), .DEPTH(DEPTH)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_b), .s_valid(s_valid_b),
    .s_ready(s_ready_b), .parity_mode(pm_b), .two_stop(ts_b), .tx(tx_b),
    .busy(busy_b), .frame_done(done_b), .fifo_count(count_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0] mq   [2][$];   // accepted words awaiting transmission
  logic [2:0] wave [2][$];   // pending per-cycle {tx,busy,done} samples
  logic [2:0] exp_out [2];
  bit         cur_idle [2];
  int         dbits [2] = '{8, 5};

  int busy_cyc_a, done_cnt_a, busy_cyc_b, done_cnt_b;

  task automatic model_edge(input int id);
    logic       v, ts, par;
    logic [8:0] d, w;
    logic [1:0] pm;
    logic [2:0] e;
    int         sz, nb, n;
    bit         bits[$];
    if (id == 0) begin
      v = s_valid_a; d = {1'b0, s_data_a}; pm = pm_a; ts = ts_a;
    end else begin
      v = s_valid_b; d = {4'b0, s_data_b}; pm = pm_b; ts = ts_b;
    end
    if (!rst_n) begin
      mq[id].delete();
      wave[id].delete();
      exp_out[id]  = 3'b100;
      cur_idle[id] = 1'b1;
      return;
    end
    sz = mq[id].size();
    // A frame may only start from a cycle in which the line was idle.
    if (cur_idle[id] && sz != 0) begin
      w   = mq[id].pop_front();
      par = 1'b0;
      bits.push_back(1'b0);
      for (int i = 0; i < dbits[id]; i++) begin
        bits.push_back(w[i]);
        par ^= w[i];
      end
      if (pm == 2'b01)      bits.push_back(par);
      else if (pm == 2'b10) bits.push_back(!par);
      bits.push_back(1'b1);
      if (ts) bits.push_back(1'b1);
      nb = bits.size();
      n  = 0;
      foreach (bits[k]) begin
        for (int c = 0; c < BP; c++) begin
          n++;
          e = {bits[k], 1'b1, (n == nb * BP)};
          wave[id].push_back(e);
        end
      end
    end
    if (v && sz != DEPTH) mq[id].push_back(d);
    if (wave[id].size() != 0) begin
      exp_out[id]  = wave[id].pop_front();
      cur_idle[id] = 1'b0;
    end else begin
      exp_out[id]  = 3'b100;
      cur_idle[id] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check("tx_a",    tx_a,      exp_out[0][2]);
    check("busy_a",  busy_a,    exp_out[0][1]);
    check("done_a",  done_a,    exp_out[0][0]);
    check("count_a", count_a,   mq[0].size());
    check("ready_a", s_ready_a, mq[0].size() != DEPTH);
    check("tx_b",    tx_b,      exp_out[1][2]);
    check("busy_b",  busy_b,    exp_out[1][1]);
    check("done_b",  done_b,    exp_out[1][0]);
    check("count_b", count_b,   mq[1].size());
    check("ready_b", s_ready_b, mq[1].size() != DEPTH);
    busy_cyc_a += int'(busy_a);
    done_cnt_a += int'(done_a);
    busy_cyc_b += int'(busy_b);
    done_cnt_b += int'(done_b);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_tally();
    busy_cyc_a = 0; done_cnt_a = 0; busy_cyc_b = 0; done_cnt_b = 0;
  endtask

  task automatic drain(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy_a && !busy_b && count_a == 0 && count_b == 0) break;
      step();
    end
    check(tag, {busy_a, busy_b, |count_a, |count_b}, 4'b0000);
  endtask

  task automatic push_a(input logic [7:0] d, input logic [1:0] pm, input logic ts);
    s_data_a = d; pm_a = pm; ts_a = ts; s_valid_a = 1'b1;
    step();
    s_valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [4:0] d, input logic [1:0] pm, input logic ts);
    s_data_b = d; pm_b = pm; ts_b = ts; s_valid_b = 1'b1;
    step();
    s_valid_b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int   n_acc;
  logic hs, ready_low_seen;

  initial begin
    rst_n = 1'b0;
    s_data_a = '0; s_valid_a = 1'b0; pm_a = 2'b00; ts_a = 1'b0;
    s_data_b = '0; s_valid_b = 1'b0; pm_b = 2'b00; ts_b = 1'b0;
    clear_tally();
    run(2);
    check("rst_tx",    tx_a,      1);
    check("rst_busy",  busy_a,    0);
    check("rst_done",  done_a,    0);
    check("rst_ready", s_ready_a, 1);
    check("rst_count", count_a,   0);
    rst_n = 1'b1;
    run(3);

    // 1: 0x55, no parity, one stop
    clear_tally();
    push_a(8'h55, 2'b00, 1'b0);
    drain("s1_drain", 400);
    check("s1_busy_cycles", busy_cyc_a, 100);
    check("s1_done_pulses", done_cnt_a, 1);

    // 2: 0xA7 even then odd parity
    clear_tally();
    push_a(8'hA7, 2'b01, 1'b0);
    drain("s2e_drain", 400);
    push_a(8'hA7, 2'b10, 1'b0);
    drain("s2o_drain", 400);
    check("s2_busy_cycles", busy_cyc_a, 220);
    check("s2_done_pulses", done_cnt_a, 2);

    // 3: 0x3C, two stop bits
    clear_tally();
    push_a(8'h3C, 2'b00, 1'b1);
    drain("s3_drain", 400);
    check("s3_busy_cycles", busy_cyc_a, 110);

    // 4: hold s_valid for six words while idle
    clear_tally();
    ts_a = 1'b0; pm_a = 2'b00;
    n_acc = 0; ready_low_seen = 1'b0;
    s_data_a = 8'h10; s_valid_a = 1'b1;
    for (int i = 0; i < 1000 && n_acc < 6; i++) begin
      hs = s_ready_a;
      if (!s_ready_a) ready_low_seen = 1'b1;
      step();
      if (hs) begin
        n_acc++;
        s_data_a = 8'h10 + 8'(n_acc);
      end
    end
    s_valid_a = 1'b0;
    check("s4_accepted", n_acc, 6);
    check("s4_ready_dropped", ready_low_seen, 1);
    drain("s4_drain", 1000);
    check("s4_busy_cycles", busy_cyc_a, 600);
    check("s4_done_pulses", done_cnt_a, 6);

    // 5: reset during data bit 3 with two words queued
    s_valid_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data_a = 8'hC0 + 8'(i);
      step();
    end
    s_valid_a = 1'b0;
    run(42);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("s5_tx",    tx_a,    1);
    check("s5_busy",  busy_a,  0);
    check("s5_count", count_a, 0);
    clear_tally();
    run(300);
    check("s5_no_frames", busy_cyc_a, 0);

    // 6: five-bit build, 0x13 with even parity
    clear_tally();
    push_b(5'h13, 2'b01, 1'b0);
    drain("s6_drain", 400);
    check("s6_busy_cycles", busy_cyc_b, 80);
    check("s6_done_pulses", done_cnt_b, 1);

    // random traffic with configuration changes at arbitrary times
    for (int i = 0; i < 3000; i++) begin
      s_valid_a = ($urandom_range(0, 99) < 30);
      s_data_a  = 8'($urandom);
      s_valid_b = ($urandom_range(0, 99) < 30);
      s_data_b  = 5'($urandom);
      if ($urandom_range(0, 39) == 0) begin pm_a = 2'($urandom); ts_a = 1'($urandom); end
      if ($urandom_range(0, 39) == 0) begin pm_b = 2'($urandom); ts_b = 1'($urandom); end
      step();
    end
    s_valid_a = 1'b0;
    s_valid_b = 1'b0;
    drain("rand_drain", 2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 single-byte transmitter. Data width and FIFO depth are set at elaboration. Parity mode and stop-bit count are selected at run time. A DEPTH-entry FIFO with a valid/ready handshake feeds the serialiser, so upstream logic (gyroscope sample formatter) can burst several words without waiting per frame. The block drives the board UART TX pin.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; BIT_PERIOD = CLK_FREQ / BAUD_RATE (integer, truncated), must be >= 2
DATA_BITS, 8, data bits per frame, legal range 5..9
DEPTH, 16, FIFO entries, power of two, >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
s_data  in  DATA_BITS  word to transmit
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept; a word is written on a cycle with s_valid && s_ready
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
two_stop  in  1  0 = one stop bit, 1 = two stop bits
tx  out  1  serial line, idle high
busy  out  1  high from first cycle of start bit to last cycle of final stop bit
frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit
fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset: applied on a clk edge with rst_n=0; tx=1, busy=0, frame_done=0, s_ready=1, fifo_count=0. FIFO is flushed and the FSM goes to IDLE. Reset mid-frame aborts the frame and tx is 1 after that edge.
- FIFO:
  - s_ready = (fifo_count != DEPTH), derived from registered count only; no write-through when full.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - A pop happens only in IDLE when fifo_count != 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head, load the shift register, and latch parity_mode and two_stop. Go to START; tx=0 from the next cycle.
  - START: tx=0 for BIT_PERIOD cycles, then DATA.
  - DATA: DATA_BITS bits, LSB first, each held BIT_PERIOD cycles. Then PARITY if the latched mode is even/odd, else STOP.
  - PARITY: tx = XOR of the data for even, its inverse for odd; held BIT_PERIOD cycles.
  - STOP: tx=1 for BIT_PERIOD cycles (1 stop) or 2*BIT_PERIOD cycles (2 stops). frame_done pulses on the last cycle, then IDLE.
  - Back-to-back frames: IDLE lasts exactly one cycle between frames (tx=1), so the inter-frame gap is one clock.
- Timing:
  - Bit timer counts 0..BIT_PERIOD-1 and resets at each bit boundary. Width is $clog2(BIT_PERIOD).
  - Frame length in cycles = BIT_PERIOD*(1+DATA_BITS+P+S), where P is 0 or 1 and S is 1 or 2.
- Config changes: parity_mode and two_stop may change at any time. They take effect only at the next frame's IDLE pop.
- Outputs: tx, busy and frame_done are registered; no combinational path from any input to tx.

Decomposition:
- Package uart_pkg:
  - parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD)
  - tx_state_e enum (the five FSM states)
  - function bit_period(clk_freq, baud)
- Sub-module sync_fifo (parameters WIDTH, DEPTH): synchronous single-clock FIFO with push/pop/count/full/empty. It is reusable by the planned uart_rx successor.
- Elaboration-time assertions check the DATA_BITS range, that DEPTH is a power of two, and BIT_PERIOD >= 2.

Test Plan:
All scenarios use CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BIT_PERIOD=10), DATA_BITS=8, DEPTH=4.
1. Push 0x55, parity none, two_stop=0 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles. busy high 100 cycles; frame_done pulses once on cycle 100.
2. Push 0xA7 with even parity, then again with odd parity -> parity bit 1 (even) and 0 (odd); frame 110 cycles each.
3. Push 0x3C with two_stop=1, parity none -> stop high for 20 cycles; busy high 110 cycles.
4. Hold s_valid for 6 words while idle -> word 1 is popped immediately; s_ready drops once fifo_count=4 (5 words accepted). Six frames are sent in order with one-cycle idle gaps; fifo_count reaches 0 and s_ready returns to 1.
5. Assert rst_n=0 for one cycle during data bit 3 of a frame with 2 words queued -> tx=1, busy=0, fifo_count=0 after the edge; no further frames are sent.
6. DATA_BITS=5 build: push 5'h13, even parity -> bits 1,1,0,0,1, parity 1; frame 80 cycles.
